// File: rtl/display_scan_controller.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
//
// Holds a 32-bit hex value and lights one digit at a time. Each digit is lit
// for COUNT_MAX cycles (SHOW). All digits are then dark for BLANK_CYCLES cycles
// (BLANK) before the index advances. New values are accepted into a one-entry
// pending buffer over a valid/ready handshake. They are committed to the
// display only when the digit index wraps to 0, so a frame never tears.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   value_in    hex value offered; nibble i belongs to digit i
//   load_valid  value_in is offered
//   load_ready  pending buffer empty; transfer on load_valid && load_ready
//   blank_lz    1 = suppress leading zeros
//   digit_sel   current digit index (anode decoder input)
//   digit_en    1 = SHOW phase, 0 = BLANK phase
//   nibble      hex nibble of the current digit
//   segments    active-low segments {g,f,e,d,c,b,a}
//   frame_done  one-cycle pulse when digit_sel wraps to 0
module display_scan_controller #(
  parameter int unsigned COUNT_MAX    = 100000,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned DIGITS       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] value_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [2:0]  digit_sel,
  output logic        digit_en,
  output logic [3:0]  nibble,
  output logic [6:0]  segments,
  output logic        frame_done
);

  localparam int unsigned PrescW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
  localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(COUNT_MAX - 1);
  localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);
  localparam logic [2:0]        DigitLast = 3'(DIGITS - 1);

  typedef enum logic [0:0] {StShow, StBlank} state_e;

  state_e              state_q, state_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [BlankW-1:0]   blank_q, blank_d;
  logic [2:0]          digit_q, digit_d;
  logic                en_q, en_d;
  logic                frame_q, frame_d;
  logic [31:0]         disp_q, disp_d;
  logic [31:0]         pend_q, pend_d;
  logic                ready_q, ready_d;

  logic                advance;
  logic                wrap;
  logic                xfer;

  logic [7:0]          zero_from;
  logic                zero_run;
  logic                suppress;
  logic [6:0]          seg_raw;

  // ---------------------------------------------------------------------------
  // Scan FSM, digit index and load buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    blank_d = blank_q;
    digit_d = digit_q;
    en_d    = en_q;
    disp_d  = disp_q;
    pend_d  = pend_q;
    ready_d = ready_q;
    advance = 1'b0;
    wrap    = 1'b0;
    xfer    = load_valid && ready_q;

    case (state_q)
      StShow: begin
        if (presc_q == PrescLast) begin
          state_d = StBlank;
          presc_d = '0;
          en_d    = 1'b0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      StBlank: begin
        if (blank_q == BlankLast) begin
          state_d = StShow;
          blank_d = '0;
          en_d    = 1'b1;
          advance = 1'b1;
        end else begin
          blank_d = blank_q + 1'b1;
        end
      end
      default: begin
        state_d = StShow;
      end
    endcase

    if (advance) begin
      if (digit_q == DigitLast) begin
        digit_d = '0;
        wrap    = 1'b1;
      end else begin
        digit_d = digit_q + 3'd1;
      end
    end

    frame_d = wrap;

    // A transfer needs ready_q=1, i.e. an empty buffer, so it never coincides
    // with a commit. A value captured on the wrap edge waits for the next frame.
    if (xfer) begin
      pend_d  = value_in;
      ready_d = 1'b0;
    end else if (wrap && !ready_q) begin
      disp_d  = pend_q;
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StShow;
      presc_q <= '0;
      blank_q <= '0;
      digit_q <= '0;
      en_q    <= 1'b1;
      frame_q <= 1'b0;
      disp_q  <= '0;
      pend_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      blank_q <= blank_d;
      digit_q <= digit_d;
      en_q    <= en_d;
      frame_q <= frame_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Segment decode and leading-zero suppression
  // ---------------------------------------------------------------------------
  always_comb begin
    nibble = disp_q[{digit_q, 2'b00} +: 4];

    // zero_from[k] = 1 when nibbles k..DIGITS-1 are all zero.
    zero_run  = 1'b1;
    zero_from = '0;
    for (int k = 7; k >= 0; k--) begin
      if (k < int'(DIGITS)) begin
        zero_run     = zero_run && (disp_q[4*k +: 4] == 4'h0);
        zero_from[k] = zero_run;
      end
    end

    suppress = blank_lz && (digit_q != 3'd0) && zero_from[digit_q];

    case (nibble)
      4'h0:    seg_raw = 7'b1000000;
      4'h1:    seg_raw = 7'b1111001;
      4'h2:    seg_raw = 7'b0100100;
      4'h3:    seg_raw = 7'b0110000;
      4'h4:    seg_raw = 7'b0011001;
      4'h5:    seg_raw = 7'b0010010;
      4'h6:    seg_raw = 7'b0000010;
      4'h7:    seg_raw = 7'b1111000;
      4'h8:    seg_raw = 7'b0000000;
      4'h9:    seg_raw = 7'b0010000;
      4'hA:    seg_raw = 7'b0001000;
      4'hB:    seg_raw = 7'b0000011;
      4'hC:    seg_raw = 7'b1000110;
      4'hD:    seg_raw = 7'b0100001;
      4'hE:    seg_raw = 7'b0000110;
      default: seg_raw = 7'b0001110;
    endcase

    segments = suppress ? 7'b1111111 : seg_raw;
  end

  assign digit_sel  = digit_q;
  assign digit_en   = en_q;
  assign load_ready = ready_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller (COUNT_MAX=4, BLANK_CYCLES=2,
// DIGITS=8). Accepted transfers are queued with the cycle they were offered in
// and are committed to the expected display at the next frame wrap that
// follows the capture. Every cycle, all outputs are compared against the
// expected scan position and display contents.
module tb_display_scan_controller;

  localparam int CountMax = 4;
  localparam int BlankCyc = 2;
  localparam int NDigits  = 8;
  localparam int Per      = CountMax + BlankCyc;
  localparam int Frame    = NDigits * Per;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] value_in;
  logic        load_valid;
  logic        load_ready;
  logic        blank_lz;
  logic [2:0]  digit_sel;
  logic        digit_en;
  logic [3:0]  nibble;
  logic [6:0]  segments;
  logic        frame_done;

  display_scan_controller #(
    .COUNT_MAX   (CountMax),
    .BLANK_CYCLES(BlankCyc),
    .DIGITS      (NDigits)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .value_in  (value_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .blank_lz  (blank_lz),
    .digit_sel (digit_sel),
    .digit_en  (digit_en),
    .nibble    (nibble),
    .segments  (segments),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    int          stamp;
  } xfer_t;

  xfer_t       sb[$];
  logic [31:0] exp_disp;
  int          c;
  int          tests;
  int          failed;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Expected outputs follow from the cycle number since reset release.
  task automatic check_outputs();
    int         d;
    logic       en;
    logic       fd;
    logic       lz;
    logic [3:0] nib;
    logic [6:0] seg;
    d   = (c / Per) % NDigits;
    en  = (c % Per) < CountMax;
    fd  = (c > 0) && (c % Frame == 0);
    nib = exp_disp[4*d +: 4];
    lz  = blank_lz && (d > 0) && ((exp_disp >> (4 * d)) == 32'h0);
    seg = lz ? 7'b1111111 : seg_of(nib);
    check_eq("digit_sel", digit_sel, d);
    check_eq("digit_en", digit_en, en);
    check_eq("frame_done", frame_done, fd);
    check_eq("load_ready", load_ready, sb.size() == 0);
    check_eq("nibble", nibble, nib);
    check_eq("segments", segments, seg);
  endtask

  // Advance one cycle: record a transfer offered in the current cycle, move to
  // the next negedge, commit at a frame wrap, then compare.
  task automatic step();
    xfer_t x;
    if (load_valid && sb.size() == 0) sb.push_back('{value_in, c});
    @(negedge clk);
    c++;
    if ((c % Frame == 0) && (sb.size() > 0) && (sb[0].stamp + 2 <= c)) begin
      x        = sb.pop_front();
      exp_disp = x.val;
    end
    check_outputs();
  endtask

  task automatic run_to(input int target);
    while (c < target) step();
  endtask

  initial begin
    tests      = 0;
    failed     = 0;
    c          = 0;
    exp_disp   = '0;
    reset_n    = 1'b0;
    load_valid = 1'b0;
    value_in   = '0;
    blank_lz   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_outputs();
    check_eq("rst_segments", segments, 7'b1000000);
    check_eq("rst_ready", load_ready, 1'b1);

    // Load while pending is empty; a second offer while full must be ignored.
    run_to(2);
    load_valid = 1'b1;
    value_in   = 32'h1234ABCD;
    run_to(3);
    check_eq("ready_low", load_ready, 1'b0);
    value_in = 32'hFFFFFFFF;
    run_to(6);
    check_eq("sel1_at6", digit_sel, 3'd1);
    check_eq("en_at6", digit_en, 1'b1);
    run_to(12);
    check_eq("sel2_at12", digit_sel, 3'd2);
    run_to(20);
    load_valid = 1'b0;
    run_to(47);
    check_eq("no_fd_47", frame_done, 1'b0);
    run_to(48);
    check_eq("fd_48", frame_done, 1'b1);
    check_eq("commit_nib", nibble, 4'hD);
    check_eq("commit_seg", segments, 7'b0100001);
    check_eq("commit_ready", load_ready, 1'b1);
    run_to(49);
    check_eq("fd_49", frame_done, 1'b0);
    run_to(90);
    check_eq("d7_nib", nibble, 4'h1);
    check_eq("d7_seg", segments, 7'b1111001);

    // Transfer in the wrap cycle: captured now, shown one frame later.
    run_to(96);
    check_eq("fd_96", frame_done, 1'b1);
    check_eq("keep_nib_96", nibble, 4'hD);
    load_valid = 1'b1;
    value_in   = 32'h000000A5;
    run_to(97);
    load_valid = 1'b0;
    check_eq("wrap_cap_ready", load_ready, 1'b0);
    run_to(100);
    blank_lz = 1'b1;
    run_to(143);
    check_eq("old_val_143", nibble, 4'h1);
    run_to(144);
    check_eq("fd_144", frame_done, 1'b1);
    check_eq("a5_d0_seg", segments, 7'b0010010);
    run_to(150);
    check_eq("a5_d1_seg", segments, 7'b0001000);
    load_valid = 1'b1;
    value_in   = 32'h0;
    run_to(151);
    load_valid = 1'b0;
    run_to(156);
    check_eq("a5_d2_lz_seg", segments, 7'b1111111);
    check_eq("a5_d2_nib", nibble, 4'h0);
    check_eq("a5_d2_en", digit_en, 1'b1);
    run_to(167);
    blank_lz = 1'b0;
    run_to(170);
    check_eq("a5_d4_nolz", segments, 7'b1000000);

    // Value zero with suppression: only digit 0 lit.
    run_to(192);
    check_eq("zero_d0_seg", segments, 7'b1000000);
    blank_lz = 1'b1;
    run_to(198);
    check_eq("zero_d1_lz", segments, 7'b1111111);
    run_to(200);
    load_valid = 1'b1;
    value_in   = 32'h000000A5;
    run_to(201);
    load_valid = 1'b0;
    run_to(239);
    blank_lz = 1'b0;
    run_to(240);
    check_eq("a5_again_nib", nibble, 4'h5);
    run_to(252);
    check_eq("a5_d2_nolz", segments, 7'b1000000);

    // Reset during BLANK of digit 5 with pending full drops the pending value.
    run_to(255);
    load_valid = 1'b1;
    value_in   = 32'hDEADBEEF;
    run_to(256);
    load_valid = 1'b0;
    check_eq("pend_full", load_ready, 1'b0);
    run_to(274);
    check_eq("pre_rst_sel", digit_sel, 3'd5);
    check_eq("pre_rst_en", digit_en, 1'b0);
    reset_n = 1'b0;
    #1;
    check_eq("arst_sel", digit_sel, 3'd0);
    check_eq("arst_en", digit_en, 1'b1);
    check_eq("arst_ready", load_ready, 1'b1);
    check_eq("arst_fd", frame_done, 1'b0);
    check_eq("arst_seg", segments, 7'b1000000);
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
    exp_disp = '0;
    c        = 0;
    check_outputs();
    run_to(48);
    check_eq("post_rst_fd", frame_done, 1'b1);
    check_eq("post_rst_nib", nibble, 4'h0);
    check_eq("post_rst_ready", load_ready, 1'b1);
    run_to(60);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
